sen_lut_pipe: RTL and testbench
===============================

SEN_LUT_PIPE -- requirements
Module: sen_lut_pipe

Interface
REQ-001 Parameter PHASE_W, default 32: angle/phase width; full circle = 2^PHASE_W.
REQ-002 Parameter DATA_W, default 16: signed sample width, range +/-(2^(DATA_W-1)-1).
REQ-003 Parameter ADDR_W, default 8: quarter-wave table depth 2^ADDR_W; ADDR_W <= PHASE_W-2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  input beat offered.
REQ-007 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 in_angle  input  PHASE_W  absolute angle (mode 0) or phase step (mode 1).
REQ-009 mode  input  1  0 = direct lookup, 1 = NCO accumulate; sampled with each accepted beat.
REQ-010 acc_clr  input  1  synchronous clear of the phase accumulator.
REQ-011 out_valid  output  1  output sample present.
REQ-012 out_ready  input  1  downstream accepts sample.
REQ-013 out_sin  output  DATA_W  signed sine sample.
REQ-014 out_cos  output  DATA_W  signed cosine sample (see Configuration).

Function
REQ-015 Table entry t[i] SHALL equal round-to-nearest of (2^(DATA_W-1)-1)*sin((i+0.5)*(pi/2)/2^ADDR_W), i in [0, 2^ADDR_W).
REQ-016 Lookup phase p: quadrant q = p[PHASE_W-1:PHASE_W-2], index i = next ADDR_W bits; remaining low bits truncated.
REQ-017 Sine SHALL be q0: t[i]; q1: t[~i]; q2: -t[i]; q3: -t[~i] (~i = bitwise inverse within ADDR_W bits).
REQ-018 Cosine SHALL use the same rule with quadrant q+1 (mod 4) and the same index.
REQ-019 Mode 0: p = in_angle; accumulator unchanged.
REQ-020 Mode 1: p = acc + in_angle, and acc <= acc + in_angle, wrapping modulo 2^PHASE_W.
REQ-021 acc_clr SHALL zero acc before any same-cycle accepted mode-1 beat adds to it (result: p = acc = in_angle).
REQ-022 Three register stages (phase/quadrant, table read, sign/mirror apply); latency from accepted beat to out_valid = 3 cycles with out_ready held high.
REQ-023 Global pipeline enable en = out_ready || !out_valid; all stages advance only when en is high.
REQ-024 in_ready SHALL equal en (combinational); throughput one sample per cycle when out_ready stays high.
REQ-025 When out_valid && !out_ready, out_sin, out_cos, out_valid and all stage registers SHALL hold unchanged.
REQ-026 Beats are delivered in acceptance order, no drop, no duplication; bubbles propagate as invalid stages.

Reset
REQ-027 rst_n low SHALL immediately clear out_valid, all stage valid flags, acc, out_sin and out_cos to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; first beat accepted after release appears 3 cycles later.
REQ-029 in_ready SHALL be 1 while in reset-released idle (out_valid = 0).

Configuration
REQ-030 Macro SEN_LUT_COS_EN defined: cosine path built per REQ-018, out_cos valid with out_sin.
REQ-031 Macro SEN_LUT_COS_EN undefined: cosine path removed, out_cos tied to 0; sine behaviour and latency unchanged.

Verification (PHASE_W=32, DATA_W=16, ADDR_W=8, SEN_LUT_COS_EN defined)
REQ-032 Mode 0, in_angle 0x0000_0000, out_ready 1 -> 3 cycles later out_sin = 101, out_cos = 32767.
REQ-033 Mode 0, angles 0x4000_0000 then 0x8000_0000 back-to-back -> out_sin 32767 then -101, out_cos -101 then -32767, consecutive cycles.
REQ-034 Mode 1, acc_clr with first beat, step 0x4000_0000 x5 -> out_sin sequence 32767, -101, -32767, 101, 32767 (wrap).
REQ-035 Valid output, out_ready low 5 cycles while in_valid high -> in_ready 0, outputs stable; on release one sample per cycle, none lost.
REQ-036 rst_n pulsed low with 3 beats in flight -> out_valid 0 at once, acc 0; no stale sample after release.
REQ-037 Macro undefined, REQ-032 stimulus -> out_sin = 101, out_cos = 0, latency 3.

Source files
------------

// File: rtl/sen_lut_pipe.sv
// Quarter-wave sine/cosine LUT with optional NCO phase accumulator; cosine path built only with SEN_LUT_COS_EN.
// Three register stages (latency 3); one global enable stalls the whole pipe while out_valid && !out_ready.
module sen_lut_pipe #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PHASE_W-1:0]        in_angle,
  input  logic                      mode,
  input  logic                      acc_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_sin,
  output logic signed [DATA_W-1:0]  out_cos
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAG_W = DATA_W - 1;
  localparam int TOP   = ADDR_W + 2;
  localparam int FRAC  = 60;

  // Elaboration-time sin() in Q60 fixed point (Taylor series), rounded to the sample scale.
  function automatic logic [MAG_W-1:0] lut_val(input int idx);
    logic [127:0] x, x2, term, s, amp, prod;
    x    = (128'h3243F6A8885A308D * 128'(2 * idx + 1)) >> (ADDR_W + 2);
    x2   = (x * x) >> FRAC;
    term = x;
    s    = x;
    for (int k = 1; k <= 12; k++) begin
      term = ((term * x2) >> FRAC) / 128'(2 * k * (2 * k + 1));
      if ((k % 2) != 0) s = s - term;
      else              s = s + term;
    end
    amp  = (128'd1 << (DATA_W - 1)) - 128'd1;
    prod = (amp * s + (128'd1 << (FRAC - 1))) >> FRAC;
    return prod[MAG_W-1:0];
  endfunction

  logic [MAG_W-1:0] rom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = lut_val(g);
    assign rom[g] = ENTRY;
  end

  logic                en;
  logic                accept;
  logic [PHASE_W-1:0]  acc;
  logic [PHASE_W-1:0]  acc_base;
  logic [PHASE_W-1:0]  acc_sum;
  logic [TOP-1:0]      p_top;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;
  assign accept   = in_valid && en;
  // Clear takes effect before a same-cycle NCO step is added.
  assign acc_base = acc_clr ? '0 : acc;
  assign acc_sum  = acc_base + in_angle;
  assign p_top    = mode ? acc_sum[PHASE_W-1 -: TOP] : in_angle[PHASE_W-1 -: TOP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc <= '0;
    else if (accept && mode) acc <= acc_sum;
    else if (acc_clr)        acc <= '0;
  end

  // Stage 1: quadrant and table index.
  logic              s1_vld;
  logic [1:0]        s1_q;
  logic [ADDR_W-1:0] s1_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
      s1_idx <= '0;
    end else if (en) begin
      s1_vld <= in_valid;
      s1_q   <= p_top[TOP-1 -: 2];
      s1_idx <= p_top[ADDR_W-1:0];
    end
  end

  // Stage 2: table read with index mirroring; odd quadrants read the reflected entry.
  logic              s2_vld;
  logic [MAG_W-1:0]  s2_sin_mag;
  logic              s2_sin_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld     <= 1'b0;
      s2_sin_mag <= '0;
      s2_sin_neg <= 1'b0;
    end else if (en) begin
      s2_vld     <= s1_vld;
      s2_sin_mag <= rom[s1_q[0] ? ~s1_idx : s1_idx];
      s2_sin_neg <= s1_q[1];
    end
  end

  // Stage 3: sign apply into the output registers.
  logic signed [DATA_W-1:0] sin_pos;
  assign sin_pos = {1'b0, s2_sin_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sin   <= '0;
    end else if (en) begin
      out_valid <= s2_vld;
      out_sin   <= s2_sin_neg ? -sin_pos : sin_pos;
    end
  end

`ifdef SEN_LUT_COS_EN
  // Cosine is sine one quadrant ahead: mirror sense flips, sign is q[1]^q[0].
  logic [MAG_W-1:0]         s2_cos_mag;
  logic                     s2_cos_neg;
  logic signed [DATA_W-1:0] cos_pos;
  assign cos_pos = {1'b0, s2_cos_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_cos_mag <= '0;
      s2_cos_neg <= 1'b0;
      out_cos    <= '0;
    end else if (en) begin
      s2_cos_mag <= rom[s1_q[0] ? s1_idx : ~s1_idx];
      s2_cos_neg <= s1_q[1] ^ s1_q[0];
      out_cos    <= s2_cos_neg ? -cos_pos : cos_pos;
    end
  end
`else
  assign out_cos = '0;
`endif

endmodule

// File: tb/tb_sen_lut_pipe.sv
// Scoreboard bench for sen_lut_pipe: directed angles with hand-computed samples.
module tb_sen_lut_pipe;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [31:0]         in_angle = '0;
  logic                mode = 1'b0;
  logic                acc_clr = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [15:0]  out_sin;
  logic signed [15:0]  out_cos;

  sen_lut_pipe #(.PHASE_W(32), .DATA_W(16), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .out_cos   (out_cos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int s;
    int c;
    int t;
    string name;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  function automatic int xc(input int v);
`ifdef SEN_LUT_COS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: a sample is consumed at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_sin"}, int'(out_sin), e.s);
        check({e.name, "_cos"}, int'(out_cos), e.c);
        if (e.t >= 0) check({e.name, "_latency"}, cyc, e.t);
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input string name, input logic [31:0] ang, input logic m,
                      input logic clr, input int es, input int ecs, input bit chk_lat);
    bit rdy;
    bit done;
    int c;
    exp_t x;
    done     = 1'b0;
    c        = 0;
    in_valid = 1'b1;
    in_angle = ang;
    mode     = m;
    acc_clr  = clr;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      c   = cyc;
      @(posedge clk);
      done = rdy;
    end
    if (!done) begin
      check({name, "_accept_timeout"}, 0, 1);
    end else begin
      x.s = es;
      x.c = ecs;
      x.t = chk_lat ? c + 3 : -1;
      x.name = name;
      sb.push_back(x);
    end
    #1;
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() > 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    check({name, "_left"}, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sin", int'(out_sin), 0);
    check("rst_out_cos", int'(out_cos), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // Direct lookups, back-to-back, with quadrant and truncation corners.
    send("m0_zero",   32'h0000_0000, 1'b0, 1'b0,    101, xc( 32767), 1'b1);
    send("m0_q1",     32'h4000_0000, 1'b0, 1'b0,  32767, xc(  -101), 1'b1);
    send("m0_q2",     32'h8000_0000, 1'b0, 1'b0,   -101, xc(-32767), 1'b1);
    send("m0_mid",    32'h2000_0000, 1'b0, 1'b0,  23241, xc( 23099), 1'b1);
    send("m0_trunc",  32'h003F_FFFF, 1'b0, 1'b0,    101, xc( 32767), 1'b1);
    send("m0_top",    32'hFFFF_FFFF, 1'b0, 1'b0,   -101, xc( 32767), 1'b1);
    send("m0_q3",     32'hC000_0000, 1'b0, 1'b0, -32767, xc(   101), 1'b1);
    drain("m0");

    // NCO: clear with the first step, then wrap through all quadrants.
    send("nco0", 32'h4000_0000, 1'b1, 1'b1,  32767, xc(  -101), 1'b1);
    send("nco1", 32'h4000_0000, 1'b1, 1'b0,   -101, xc(-32767), 1'b1);
    send("nco2", 32'h4000_0000, 1'b1, 1'b0, -32767, xc(   101), 1'b1);
    send("nco3", 32'h4000_0000, 1'b1, 1'b0,    101, xc( 32767), 1'b1);
    send("nco4", 32'h4000_0000, 1'b1, 1'b0,  32767, xc(  -101), 1'b1);
    // A mode-0 beat leaves acc (0x4000_0000) alone.
    send("mix_m0", 32'h0000_0000, 1'b0, 1'b0,    101, xc( 32767), 1'b1);
    send("mix_m1", 32'h4000_0000, 1'b1, 1'b0,   -101, xc(-32767), 1'b1);
    drain("nco");

    // Standalone clear with no beat offered.
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    send("clr_only", 32'h4000_0000, 1'b1, 1'b0, 32767, xc(-101), 1'b1);
    drain("clr");

    // Backpressure: fill the pipe with out_ready low, hold five cycles.
    out_ready = 1'b0;
    send("bp_a", 32'h4000_0000, 1'b0, 1'b0,  32767, xc( -101), 1'b0);
    send("bp_b", 32'h2000_0000, 1'b0, 1'b0,  23241, xc(23099), 1'b0);
    send("bp_c", 32'hC000_0000, 1'b0, 1'b0, -32767, xc(  101), 1'b0);
    in_valid = 1'b1;
    in_angle = 32'hFFFF_FFFF;
    mode     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_hold_sin", int'(out_sin), 32767);
      check("bp_hold_cos", int'(out_cos), xc(-101));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send("bp_d", 32'hFFFF_FFFF, 1'b0, 1'b0, -101, xc(32767), 1'b1);
    drain("bp");

    // Reset with three NCO beats in flight.
    send("rf0", 32'h4000_0000, 1'b1, 1'b1,  32767, xc(  -101), 1'b0);
    send("rf1", 32'h4000_0000, 1'b1, 1'b0,   -101, xc(-32767), 1'b0);
    send("rf2", 32'h4000_0000, 1'b1, 1'b0, -32767, xc(   101), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sin", int'(out_sin), 0);
    check("midrst_out_cos", int'(out_cos), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("postrst_in_ready", int'(in_ready), 1);
    // acc must restart from zero: one step lands on quadrant 1.
    send("postrst", 32'h4000_0000, 1'b1, 1'b0, 32767, xc(-101), 1'b1);
    drain("postrst");
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
